// File: rtl/cmac_tx_arb_pkg.sv
// Shared types and helpers for the CMAC TX AXIS arbiter.
package cmac_tx_arb_pkg;

    localparam int DEF_DATA_W    = 512;
    localparam int DEF_KEEP_W    = DEF_DATA_W / 8;
    localparam int DEF_MAX_BEATS = 150;
    localparam int MAX_CH        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } arb_state_t;

    // First valid channel strictly after last, wrapping within n_ch channels.
    function automatic logic [2:0] rr_next(input logic [MAX_CH-1:0] vld,
                                           input logic [2:0]        last,
                                           input int                n_ch);
        logic [2:0] g;
        logic       found;
        int         idx;
        g     = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= n_ch && !found) begin
                idx = (int'(last) + i) % n_ch;
                if (vld[3'(idx)]) begin
                    g     = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer; out_* come straight from the head register.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   count;
    logic [W-1:0] head, tail;
    logic         push, pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign pop       = out_valid & out_ready;
    // Accepting while full is fine when the head leaves in the same cycle.
    assign in_ready  = (count != 2'd2) || pop;
    assign push      = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cmac_tx_axis_arb.sv
// Packet-atomic round-robin AXIS arbiter with oversize truncation in front of CMAC TX.
// Optional statistics counters enabled by defining CMAC_TX_ARB_STATS_EN.
module cmac_tx_axis_arb
    import cmac_tx_arb_pkg::*;
#(
    parameter int   N_CH      = 3,
    parameter int   DATA_W    = DEF_DATA_W,
    parameter int   MAX_BEATS = DEF_MAX_BEATS,
    parameter int   CNT_W     = 32,
    localparam int  KEEP_W    = DATA_W / 8,
    localparam int  GW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_CH*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [N_CH-1:0]          s_axis_tvalid,
    input  logic [N_CH-1:0]          s_axis_tlast,
    input  logic [N_CH-1:0]          s_axis_tuser,
    output logic [N_CH-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic [GW-1:0]            cur_grant,
    output logic                     busy,
    output logic                     trunc_pulse
`ifdef CMAC_TX_ARB_STATS_EN
    ,
    output logic [N_CH*CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]         trunc_cnt,
    output logic [CNT_W-1:0]         drop_beat_cnt
`endif
);

    localparam int BCW = $clog2(MAX_BEATS + 1);
    localparam int SW  = DATA_W + KEEP_W + 2;

    arb_state_t          state, state_d;
    logic [GW-1:0]       last_grant, grant_d;
    logic [BCW-1:0]      beat_cnt, beat_cnt_d;
    logic [MAX_CH-1:0]   vld_ext;
    logic [DATA_W-1:0]   g_data;
    logic [KEEP_W-1:0]   g_keep;
    logic                g_valid, g_last, g_user;
    logic                skid_in_ready, push, push_last, push_user, trunc_now;
    logic [SW-1:0]       skid_out;

    assign vld_ext = MAX_CH'(s_axis_tvalid);
    assign g_data  = s_axis_tdata[cur_grant*DATA_W +: DATA_W];
    assign g_keep  = s_axis_tkeep[cur_grant*KEEP_W +: KEEP_W];
    assign g_valid = s_axis_tvalid[cur_grant];
    assign g_last  = s_axis_tlast[cur_grant];
    assign g_user  = s_axis_tuser[cur_grant];
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_d       = state;
        grant_d       = cur_grant;
        beat_cnt_d    = beat_cnt;
        s_axis_tready = '0;
        push          = 1'b0;
        push_last     = g_last;
        push_user     = g_user;
        trunc_now     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = GW'(rr_next(vld_ext, 3'(last_grant), N_CH));
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                s_axis_tready[cur_grant] = skid_in_ready;
                if (g_valid && skid_in_ready) begin
                    push = 1'b1;
                    if (g_last) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else if (beat_cnt == BCW'(MAX_BEATS - 1)) begin
                        // Close the runaway packet as errored and swallow the rest.
                        push_last  = 1'b1;
                        push_user  = 1'b1;
                        trunc_now  = 1'b1;
                        state_d    = ST_DROP;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt + BCW'(1);
                    end
                end
            end
            ST_DROP: begin
                s_axis_tready[cur_grant] = 1'b1;
                if (g_valid && g_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_grant   <= '0;
            last_grant  <= GW'(N_CH - 1);
            beat_cnt    <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            state       <= state_d;
            cur_grant   <= grant_d;
            beat_cnt    <= beat_cnt_d;
            trunc_pulse <= trunc_now;
            if (state == ST_IDLE && state_d == ST_PASS) last_grant <= grant_d;
        end
    end

    axis_skid_buf #(.W(SW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   ({g_data, g_keep, push_last, push_user}),
        .in_valid  (push),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;

`ifdef CMAC_TX_ARB_STATS_EN
    logic drop_acc;
    assign drop_acc = (state == ST_DROP) && g_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt       <= '0;
            trunc_cnt     <= '0;
            drop_beat_cnt <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push && push_last && cur_grant == GW'(c) && !(&pkt_cnt[c*CNT_W +: CNT_W]))
                    pkt_cnt[c*CNT_W +: CNT_W] <= pkt_cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (trunc_now && !(&trunc_cnt))    trunc_cnt     <= trunc_cnt + CNT_W'(1);
            if (drop_acc && !(&drop_beat_cnt)) drop_beat_cnt <= drop_beat_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cmac_tx_axis_arb.sv
// Randomized directed bench for cmac_tx_axis_arb against a packet-level reference model.
module tb_cmac_tx_axis_arb;
    localparam int N_CH = 3, DATA_W = 64, KEEP_W = 8, MAX_BEATS = 150, CNT_W = 32, GW = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } beat_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [N_CH*DATA_W-1:0] s_axis_tdata = '0;
    logic [N_CH*KEEP_W-1:0] s_axis_tkeep = '0;
    logic [N_CH-1:0] s_axis_tvalid = '0, s_axis_tlast = '0, s_axis_tuser = '0, s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready = 1'b1;
    logic [GW-1:0] cur_grant;
    logic busy, trunc_pulse;
`ifdef CMAC_TX_ARB_STATS_EN
    logic [N_CH*CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] trunc_cnt, drop_beat_cnt;
`endif

    cmac_tx_axis_arb #(.N_CH(N_CH), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .cur_grant(cur_grant), .busy(busy), .trunc_pulse(trunc_pulse)
`ifdef CMAC_TX_ARB_STATS_EN
        , .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt), .drop_beat_cnt(drop_beat_cnt)
`endif
    );

    always #2 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    beat_t ch_q[N_CH][$];
    beat_t mq[N_CH][$];
    beat_t exp_q[$], out_q[$];
    int out_cyc[$];
    logic [N_CH-1:0] fire = '0, prev_last = '1;
    int rise_cyc[N_CH];
    bit gap_en = 0, bp_en = 0;
    int trunc_seen = 0, m_last = N_CH - 1, pkt_id = 0;
    bit stalled_prev = 0;
    beat_t prev_out;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source drivers: inputs change only just after the rising edge.
    initial forever begin
        @(posedge clk); #1;
        if (reset) begin
            for (int c = 0; c < N_CH; c++) ch_q[c].delete();
            s_axis_tvalid = '0;
            prev_last = '1;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (fire[c]) begin
                    prev_last[c] = ch_q[c][0].last;
                    void'(ch_q[c].pop_front());
                end
                if (s_axis_tvalid[c] && !fire[c]) begin
                    // hold the unaccepted beat
                end else if (ch_q[c].size() > 0 &&
                             !(gap_en && !prev_last[c] && $urandom_range(3) == 0)) begin
                    if (!s_axis_tvalid[c]) rise_cyc[c] = cyc;
                    s_axis_tvalid[c] = 1'b1;
                    s_axis_tdata[c*DATA_W +: DATA_W] = ch_q[c][0].data;
                    s_axis_tkeep[c*KEEP_W +: KEEP_W] = ch_q[c][0].keep;
                    s_axis_tlast[c] = ch_q[c][0].last;
                    s_axis_tuser[c] = ch_q[c][0].user;
                end else begin
                    s_axis_tvalid[c] = 1'b0;
                end
            end
        end
        m_axis_tready = bp_en ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    // Handshake capture, output monitor and AXIS hold check.
    initial forever begin
        beat_t cur;
        @(negedge clk);
        fire = s_axis_tvalid & s_axis_tready;
        cur = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (m_axis_tvalid && stalled_prev) chk("hold", cur, prev_out);
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back(cur);
            out_cyc.push_back(cyc);
        end
        stalled_prev = m_axis_tvalid && !m_axis_tready;
        prev_out = cur;
        if (trunc_pulse) trunc_seen++;
    end

    task automatic make_pkt(int ch, int len, int umode);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {4'(ch), 12'(pkt_id), 16'(i), 32'($urandom())};
            b.last = (i == len - 1);
            b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.user = (umode == 1) ? b.last : (umode == 2) ? 1'($urandom_range(1)) : 1'b0;
            ch_q[ch].push_back(b);
            mq[ch].push_back(b);
        end
        pkt_id++;
    endtask

    // Whole packets, round-robin among channels with pending work; oversize cut at MAX_BEATS.
    task automatic model_run();
        beat_t b;
        int g, n;
        bit src_last;
        while (1) begin
            g = -1;
            for (int i = 1; i <= N_CH; i++)
                if (g < 0 && mq[(m_last + i) % N_CH].size() > 0) g = (m_last + i) % N_CH;
            if (g < 0) break;
            m_last = g;
            n = 0;
            do begin
                b = mq[g].pop_front();
                n++;
                src_last = b.last;
                if (n <= MAX_BEATS) begin
                    if (n == MAX_BEATS && !src_last) begin
                        b.last = 1'b1;
                        b.user = 1'b1;
                    end
                    exp_q.push_back(b);
                end
            end while (!src_last);
        end
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (ch_q[0].size() == 0) && (ch_q[1].size() == 0) && (ch_q[2].size() == 0) &&
                   (out_q.size() >= exp_q.size()) && !busy;
        end
        repeat (4) @(negedge clk);
        chk("drain", done, 1'b1);
    endtask

    task automatic compare_out(string tag);
        int n;
        chk({tag, ".count"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.beat%0d", tag, i), out_q[i], exp_q[i]);
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < N_CH; c++) mq[c].delete();
        m_last = N_CH - 1;
        repeat (3) @(negedge clk);
        out_q.delete(); out_cyc.delete(); exp_q.delete();
    endtask

    task automatic chk_outputs_zero(string tag);
        chk({tag, ".tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, ".tdata"}, m_axis_tdata, '0);
        chk({tag, ".tkeep"}, m_axis_tkeep, '0);
        chk({tag, ".tlast"}, m_axis_tlast, 1'b0);
        chk({tag, ".tuser"}, m_axis_tuser, 1'b0);
        chk({tag, ".s_tready"}, s_axis_tready, '0);
        chk({tag, ".grant"}, cur_grant, '0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".trunc"}, trunc_pulse, 1'b0);
`ifdef CMAC_TX_ARB_STATS_EN
        chk({tag, ".pkt_cnt"}, pkt_cnt, '0);
        chk({tag, ".trunc_cnt"}, trunc_cnt, '0);
        chk({tag, ".drop_cnt"}, drop_beat_cnt, '0);
`endif
    endtask

    initial begin
        int n;
        // 1: reset state, then a single 9-beat packet on ch1
        repeat (3) @(negedge clk);
        chk_outputs_zero("rst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle.s_tready", s_axis_tready, '0);
        chk("idle.busy", busy, 1'b0);
        make_pkt(1, 9, 0);
        model_run();
        wait_done(200);
        if (out_q.size() == 9) begin
            chk("t1.latency", out_cyc[0] - rise_cyc[1], 2);
            chk("t1.last9", out_q[8].last, 1'b1);
            chk("t1.last8", out_q[7].last, 1'b0);
        end
        compare_out("t1");

        // 2: all channels saturated, 4-beat packets, rotation and one bubble between packets
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < N_CH; c++) make_pkt(c, 4, 0);
        model_run();
        wait_done(400);
        chk("t2.first_ch", exp_q[0].data[63:60], 4'd0);
        for (int i = 1; i < out_q.size(); i++)
            chk($sformatf("t2.gap%0d", i), out_cyc[i] - out_cyc[i-1], out_q[i-1].last ? 2 : 1);
        compare_out("t2");

        // 3: backpressure 1,0,0,1 with random input gaps and tuser
        bp_en = 1; gap_en = 1;
        make_pkt(0, 16, 2);
        make_pkt(2, 7, 2);
        model_run();
        wait_done(600);
        compare_out("t3");
        bp_en = 0; gap_en = 0;

        // 4: oversize ch2 packet truncated, following ch0 packet intact
        trunc_seen = 0;
        make_pkt(2, 200, 0);
        model_run();
        repeat (20) @(negedge clk);
        make_pkt(0, 6, 0);
        model_run();
        wait_done(800);
        chk("t4.trunc_pulses", trunc_seen, 1);
        chk("t4.count", out_q.size(), 156);
        if (out_q.size() >= 150) begin
            chk("t4.b150_last", out_q[149].last, 1'b1);
            chk("t4.b150_user", out_q[149].user, 1'b1);
        end
`ifdef CMAC_TX_ARB_STATS_EN
        chk("t4.trunc_cnt", trunc_cnt, 1);
        chk("t4.drop_cnt", drop_beat_cnt, 50);
`endif
        compare_out("t4");

        // 5: tuser on the last beat only
        make_pkt(0, 5, 1);
        model_run();
        wait_done(200);
        if (out_q.size() == 5) begin
            chk("t5.user5", out_q[4].user, 1'b1);
            chk("t5.user4", out_q[3].user, 1'b0);
        end
        compare_out("t5");

        // 6: reset during beat 3 of a ch1 packet
        make_pkt(1, 8, 0);
        n = 0;
        while (ch_q[1].size() > 6 && n < 100) begin @(negedge clk); n++; end
        chk("t6.reach_beat3", ch_q[1].size(), 6);
        reset = 1'b1;
        @(negedge clk);
        chk_outputs_zero("t6.rst");
        reset = 1'b0;
        mq[1].delete();
        m_last = N_CH - 1;
        @(negedge clk);
        chk("t6.skid_empty", m_axis_tvalid, 1'b0);
        repeat (2) @(negedge clk);
        out_q.delete(); out_cyc.delete(); exp_q.delete();
        make_pkt(1, 3, 0);
        make_pkt(0, 4, 0);
        model_run();
        wait_done(200);
        if (out_q.size() > 0) chk("t6.first_ch", out_q[0].data[63:60], 4'd0);
        compare_out("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmac_tx_axis_arb.md
Name: cmac_tx_axis_arb

Overview:
Packet-atomic N-channel AXI4-Stream arbiter feeding the 512-bit CMAC TX AXIS port (tx_axis_*), clocked on txusrclk2. It replaces the fixed single-source hookup, so ERNIC TX, ERNIC send-test stream and packet generator can share one CMAC. Grants are round-robin per packet. It adds an oversize-packet guard that truncates and flags runaway packets, and a registered skid output stage that gives full throughput under tready backpressure.

Parameters:
N_CH, 3, number of input channels (2..8)
DATA_W, 512, tdata width in bits; KEEP_W = DATA_W/8
MAX_BEATS, 150, maximum beats per packet before forced truncation (>=2)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  txusrclk2 domain clock
reset  in  1  synchronous active-high reset (usr_tx_reset)
s_axis_tdata  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
s_axis_tkeep  in  N_CH*KEEP_W  per-channel tkeep
s_axis_tvalid  in  N_CH  per-channel tvalid
s_axis_tlast  in  N_CH  per-channel tlast
s_axis_tuser  in  N_CH  per-channel error flag
s_axis_tready  out  N_CH  per-channel tready
m_axis_tdata  out  DATA_W  to CMAC tx_axis_tdata
m_axis_tkeep  out  KEEP_W  to CMAC tx_axis_tkeep
m_axis_tvalid  out  1  to CMAC tx_axis_tvalid
m_axis_tlast  out  1  to CMAC tx_axis_tlast
m_axis_tuser  out  1  to CMAC tx_axis_tuser
m_axis_tready  in  1  from CMAC tx_axis_tready
cur_grant  out  $clog2(N_CH)  channel currently granted
busy  out  1  high while in PASS or DROP
trunc_pulse  out  1  one-cycle pulse when a packet is truncated

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk. Reset clears every output to 0, empties the skid buffer, sets FSM to IDLE and sets last_grant to N_CH-1, so channel 0 has first priority.
- FSM states:
  - IDLE: if any s_axis_tvalid is high, grant the first valid channel searching from (last_grant+1) mod N_CH upward with wrap. Register the result into cur_grant and last_grant, then go to PASS. No beat is accepted in the IDLE cycle.
  - PASS: s_axis_tready[g] = skid_has_space; all other tready = 0. An accepted beat pushes {tdata, tkeep, tlast, tuser} into the skid and increments beat_cnt.
    - Accepted beat with tlast=1: go to IDLE and clear beat_cnt. This costs one bubble cycle between packets.
    - Accepted beat with beat_cnt == MAX_BEATS-1 and tlast=0: push it with tlast=1 and tuser=1, pulse trunc_pulse, go to DROP.
  - DROP: s_axis_tready[g] = 1. Beats are discarded, nothing is pushed. On accepting tlast=1, go to IDLE.
- beat_cnt width is $clog2(MAX_BEATS+1) and it never wraps.
- Input tuser on any accepted beat is ORed into that beat's m_axis_tuser.
- Output stage is a 2-entry skid, so m_axis_* is fully registered.
  - Latency from input accept to m_axis_tvalid is 1 cycle.
  - skid_has_space = fewer than 2 entries, or the skid is popping this cycle.
  - Sustains 1 beat/cycle while m_axis_tready stays high.
  - m_axis_* are held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rule).
- Non-granted channels are never accepted. A channel that raises tvalid mid-packet of another channel waits for the next IDLE.
- If all channels are valid, grants rotate 0,1,2,0,… one packet each.
- busy = (state != IDLE).
- tkeep is passed through unchanged. The CMAC handles the tkeep and packet-size rules.
- Reset asserted mid-packet aborts immediately. The partial packet is lost, and the upstream source is responsible for re-framing.

Optional Feature:
Macro CMAC_TX_ARB_STATS_EN.
- When defined, adds these outputs:
  - pkt_cnt [N_CH*CNT_W]: per-channel count of packets completed to the skid, counted on tlast push including truncated ones.
  - trunc_cnt [CNT_W]: count of truncations.
  - drop_beat_cnt [CNT_W]: count of beats discarded in DROP.
- All three saturate at all-ones and clear on reset.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package cmac_tx_arb_pkg holds:
  - state typedef (IDLE, PASS, DROP);
  - a function computing the round-robin next grant from (valid vector, last_grant);
  - constants for the default DATA_W, KEEP_W and MAX_BEATS.
- One sub-module, axis_skid_buf, is natural: 2-entry, width DATA_W+KEEP_W+2, valid/ready on both sides.

Test Plan:
1. Reset then idle: all m_axis_* = 0, s_axis_tready = 0, cur_grant = 0, busy = 0. Then ch1 sends a 9-beat packet with m_axis_tready=1. Required: 9 beats out, the first appearing 2 cycles after ch1 tvalid rises; tlast on beat 9; tkeep preserved.
2. All 3 channels continuously valid with 4-beat packets, 12 packets total. Required output grant order 0,1,2,0,1,2,…; no interleaving inside a packet; exactly 1 idle cycle between packets.
3. Backpressure: m_axis_tready toggles 1,0,0,1 during a 16-beat packet. Required: no beat lost or duplicated, data stable while stalled, output sequence equal to input sequence.
4. Oversize packet with MAX_BEATS=150: ch2 sends 200 beats. Required:
   - 150 beats out, beat 150 has tlast=1 and tuser=1;
   - trunc_pulse for 1 cycle;
   - remaining 50 beats are consumed and not forwarded;
   - the next packet (ch0) is forwarded intact.
5. Input tuser=1 on the last beat of a 5-beat ch0 packet -> m_axis_tuser=1 on output beat 5 only.
6. Reset asserted on beat 3 of a ch1 packet -> next cycle all outputs are 0 and the skid is empty. After release, channel 0 gets priority and its packet passes cleanly. With CMAC_TX_ARB_STATS_EN defined, all counters read 0.
